// File: rtl/bfly_pkg.sv
// bfly_pkg: shared defaults and fixed-point helpers for the FFT butterfly datapath
package bfly_pkg;
  localparam int DW_DEF = 9;
  localparam int WW_DEF = 9;
  localparam int FRAC_DEF = 7;
  localparam int XW = 64;
  function automatic logic signed [XW-1:0] sat(input logic signed [XW-1:0] v, input int w);
    logic signed [XW-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  // Round-half-up: bias by half an LSB of the result, then floor via arithmetic shift
  function automatic logic signed [XW-1:0] rnd_shift(input logic signed [XW-1:0] v, input int n);
    return n == 0 ? v : (v + (64'sd1 <<< (n - 1))) >>> n;
  endfunction
endpackage

// File: rtl/cmul_pipe.sv
// cmul_pipe: two-stage complex multiply p = b*w or b*conj(w), rounded by 2^FRAC, with sideband
module cmul_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int SBW = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic                        conj,
  input  logic signed [DW-1:0]        b_r,
  input  logic signed [DW-1:0]        b_i,
  input  logic signed [WW-1:0]        w_r,
  input  logic signed [WW-1:0]        w_i,
  input  logic [SBW-1:0]              side_in,
  output logic                        out_valid,
  output logic signed [DW+WW+1-FRAC:0] p_r,
  output logic signed [DW+WW+1-FRAC:0] p_i,
  output logic [SBW-1:0]              side_out
);
  localparam int MW = DW + WW + 1;
  localparam int CW = DW + WW + 2;
  localparam int PW = CW - FRAC;
  logic signed [WW:0] wi_eff;
  logic signed [MW-1:0] m_rr, m_ii, m_ir, m_ri;
  logic signed [CW-1:0] c_r, c_i;
  logic [SBW-1:0] side1;
  logic v1;
  // One extra bit so negating the most negative twiddle cannot wrap
  assign wi_eff = conj ? -(WW+1)'(w_i) : (WW+1)'(w_i);
  assign c_r = CW'(m_rr) - CW'(m_ii);
  assign c_i = CW'(m_ir) + CW'(m_ri);
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1 <= 1'b0;
      side1 <= '0;
      m_rr <= '0;
      m_ii <= '0;
      m_ir <= '0;
      m_ri <= '0;
      out_valid <= 1'b0;
      side_out <= '0;
      p_r <= '0;
      p_i <= '0;
    end else if (en) begin
      v1 <= in_valid;
      side1 <= side_in;
      m_rr <= MW'(b_r) * MW'(w_r);
      m_ii <= MW'(b_i) * MW'(wi_eff);
      m_ir <= MW'(b_i) * MW'(w_r);
      m_ri <= MW'(b_r) * MW'(wi_eff);
      out_valid <= v1;
      side_out <= side1;
      p_r <= PW'(rnd_shift(XW'(c_r), FRAC));
      p_i <= PW'(rnd_shift(XW'(c_i), FRAC));
    end
endmodule

// File: rtl/bfly2_pipe.sv
// bfly2_pipe: 3-stage radix-2 butterfly y0 = a + w*b, y1 = a - w*b with inverse, /2 scaling,
// saturation and a global-stall valid/ready handshake
module bfly2_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_r,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [WW-1:0] w_r,
  input  logic signed [WW-1:0] w_i,
  input  logic                 inverse,
  input  logic                 scale_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] y0_r,
  output logic signed [DW-1:0] y0_i,
  output logic signed [DW-1:0] y1_r,
  output logic signed [DW-1:0] y1_i,
  output logic                 ovf
);
  localparam int PW = DW + WW + 2 - FRAC;
  localparam int SW = PW + 1;
  logic adv, c_valid, sc, ovf_c;
  logic signed [DW-1:0] ar, ai;
  logic signed [PW-1:0] p_r, p_i;
  logic [2*DW:0] side;
  logic signed [XW-1:0] s [4];
  logic signed [XW-1:0] v [4];
  logic signed [XW-1:0] q [4];
  assign adv = !out_valid || out_ready;
  assign in_ready = rst_n && adv;
  assign {ar, ai, sc} = side;
  cmul_pipe #(.DW(DW), .WW(WW), .FRAC(FRAC), .SBW(2*DW+1)) u_cmul (
    .clk(clk),
    .rst_n(rst_n),
    .en(adv),
    .in_valid(in_valid && in_ready),
    .conj(inverse),
    .b_r(b_r),
    .b_i(b_i),
    .w_r(w_r),
    .w_i(w_i),
    .side_in({a_r, a_i, scale_en}),
    .out_valid(c_valid),
    .p_r(p_r),
    .p_i(p_i),
    .side_out(side)
  );
  always_comb begin
    s[0] = XW'(SW'(ar) + SW'(p_r));
    s[1] = XW'(SW'(ai) + SW'(p_i));
    s[2] = XW'(SW'(ar) - SW'(p_r));
    s[3] = XW'(SW'(ai) - SW'(p_i));
    ovf_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v[k] = sc ? rnd_shift(s[k], 1) : s[k];
      q[k] = sat(v[k], DW);
      ovf_c = ovf_c | (q[k] != v[k]);
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      y0_r <= '0;
      y0_i <= '0;
      y1_r <= '0;
      y1_i <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      out_valid <= c_valid;
      y0_r <= DW'(q[0]);
      y0_i <= DW'(q[1]);
      y1_r <= DW'(q[2]);
      y1_i <= DW'(q[3]);
      ovf <= c_valid && ovf_c;
    end
endmodule

// File: doc/bfly2_pipe.md
Name: bfly2_pipe

Overview:
- Parametrised, pipelined radix-2 complex butterfly for the DIT/IDIT FFT datapath.
- Computes y0 = a + w·b and y1 = a − w·b.
- Adds the following, none of which the combinational butterfly has:
  - runtime inverse mode (conjugated twiddle, for IDIT);
  - optional per-stage ÷2 scaling with round-half-up;
  - saturation with an overflow flag;
  - valid/ready flow control.
- Sits between the stage data RAM read port and the write-back port of each FFT stage.

Parameters:
- DW, 9, signed data width of a, b, y0, y1 (each real/imag part).
- WW, 9, signed twiddle width.
- FRAC, 7, twiddle fractional bits; 1.0 = 2^FRAC, which must be representable in WW bits (FRAC ≤ WW−2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_r, a_i  in  DW each  signed upper operand.
- b_r, b_i  in  DW each  signed lower operand.
- w_r, w_i  in  WW each  signed twiddle.
- inverse  in  1  1 = use conj(w); sampled with the beat.
- scale_en  in  1  1 = divide results by 2; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y0_r, y0_i, y1_r, y1_i  out  DW each  signed results.
- ovf  out  1  any of the four results saturated in this beat; qualified by out_valid.

Behaviour:
- Reset:
  - Reset is synchronous: when rst_n=0 at a clock edge, all stage valids clear and all outputs go to 0 (out_valid=0, y*=0, ovf=0).
  - in_ready=0 during reset.
  - A reset in the middle of a transfer discards every in-flight beat. No partial output is produced.
- Handshake:
  - A beat transfers in when in_valid & in_ready; it transfers out when out_valid & out_ready.
  - Global stall: adv = !out_valid | out_ready. in_ready = adv (when not in reset).
  - When adv=0, every pipeline register holds. Outputs stay stable while out_valid=1 and out_ready=0.
- Pipeline: 3 register stages, so latency is 3 cycles from input transfer to out_valid at full throughput. Bubbles propagate as valid=0.
  - S1, multiply:
    - Twiddle: wi_eff = inverse ? −w_i : w_i, computed at WW+1 bits so that −(−2^(WW−1)) does not wrap.
    - Register four products of width DW+WW+1: b_r·w_r, b_i·wi_eff, b_i·w_r, b_r·wi_eff.
    - Register a_r/a_i, scale_en and valid alongside.
  - S2, combine:
    - pr = b_r·w_r − b_i·wi_eff; pi = b_i·w_r + b_r·wi_eff, at width DW+WW+2.
    - Round: p = (p + 2^(FRAC−1)) >>> FRAC, arithmetic shift, i.e. round-half-up.
    - Register pr, pi at width DW+WW+2−FRAC.
  - S3, butterfly:
    - s = a ± p at width DW+WW+3−FRAC.
    - If scale_en: s = (s + 1) >>> 1.
    - Saturate each of the four results to [−2^(DW−1), 2^(DW−1)−1].
    - ovf = OR of the four saturation events.
- Arithmetic is fully signed with no intermediate truncation. Only the final saturation clamps values.
- inverse and scale_en may change on every beat; each applies only to the beat it was sampled with.

Decomposition:
- Package bfly_pkg:
  - default DW/WW/FRAC localparams;
  - function sat(value, DW);
  - function rnd_shift(value, n) implementing round-half-up arithmetic shift.
- Sub-module cmul_pipe covers S1–S2: a 2-stage complex multiply with enable and conjugate input. It is reused by the planned radix-4 block.
- S3 and the stall control stay in bfly2_pipe.

Test Plan (DW=9, WW=9, FRAC=7):
- Unity twiddle: a=(10,5), b=(20,−4), w=(128,0), inverse=0, scale_en=0 → three cycles later y0=(30,1), y1=(−10,9), ovf=0.
- −j twiddle: same a, b, w=(0,−128) → y0=(6,−15), y1=(14,25). Same beat with inverse=1 → y0=(14,25), y1=(6,−15).
- Saturation and scaling:
  - a=(255,0), b=(255,0), w=(128,0), scale_en=0 → y0=(255,0), y1=(0,0), ovf=1.
  - Same operands with scale_en=1 → y0=(255,0) (511>>1), y1=(0,0), ovf=0.
- Rounding: a=0, b=(1,0), w=(64,0) → p=(1·64+64)>>7=1, so y0=(1,0), y1=(−1,0). With w=(63,0) → y0=(0,0).
- Backpressure:
  - Stream 10 beats with in_valid=1 while out_ready toggles 1,0,0,1,… → outputs appear in order, none dropped or duplicated.
  - Outputs stay stable while stalled; in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 beats in flight → next cycle out_valid=0 and y*=0. Afterwards a fresh beat emerges after 3 cycles with no stale data.
